mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, memory byte-address width; LAT, default 2, memory access cycles (legal ≥1); MAX_D_RUN, default 4, consecutive data grants allowed before a pending fetch must win.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch request, held until if_ack.
REQ-005 if_addr  in  ADDR_W  fetch address, stable while if_req.
REQ-006 if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
REQ-007 if_rdata  out  32  fetched instruction word.
REQ-008 d_req  in  1  data-access request, held until d_ack.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_addr  in  ADDR_W  data address; d_func3  in  3  access size/sign code; d_wdata  in  32  store data.
REQ-011 d_ack  out  1  one-cycle pulse; d_rdata  out  32  load data, valid with d_ack.
REQ-012 mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_func3  out  3, mem_wdata  out  32  single-port memory drive; mem_rdata  in  32  memory read data.
REQ-013 busy  out  1  high whenever state ≠ IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE; transitions: IDLE→ACCESS on any grant; ACCESS→DONE when cnt==0; DONE→IDLE unconditionally.
REQ-015 In IDLE with no request, the FSM SHALL stay in IDLE with mem_en=0.
REQ-016 In IDLE, grant SHALL go to data when d_req=1, except fetch wins when if_req=1 and d_run==MAX_D_RUN.
REQ-017 With only one requester active in IDLE, that requester SHALL be granted.
REQ-018 On grant, owner, address, func3, we (forced 0 for fetch) and wdata SHALL be registered; cnt loaded with LAT-1.
REQ-019 d_run SHALL increment on each data grant (saturating at MAX_D_RUN) and clear to 0 on each fetch grant.
REQ-020 In ACCESS, mem_en=1 and mem_addr/mem_func3/mem_wdata/mem_we SHALL come from the registered values; cnt decrements each cycle.
REQ-021 On the ACCESS cycle with cnt==0, mem_rdata SHALL be captured into the owner's rdata register; the other requester's rdata register holds its value.
REQ-022 In DONE, exactly one of if_ack/d_ack SHALL be 1 (the owner's) for exactly one cycle; mem_en=0.
REQ-023 Grant-to-ack latency SHALL be LAT+1 cycles; req-sampled-in-IDLE to ack cycle SHALL be LAT+1; back-to-back grants occur every LAT+2 cycles.
REQ-024 Requesters SHALL deassert or change req on the edge ending the ack cycle; a req still high in the following IDLE cycle is a new request.
REQ-025 Input changes during ACCESS/DONE SHALL not affect the in-flight access.
REQ-026 Stores SHALL return d_ack with d_rdata unchanged from its previous value.

Reset
REQ-027 While rst=0 at a clock edge: state=IDLE, cnt=0, d_run=0, owner=fetch, all registered operands=0, if_rdata=d_rdata=0, if_ack=d_ack=0, mem_en=mem_we=0, busy=0.
REQ-028 Reset asserted during ACCESS SHALL abort the access: mem_we=0 from the next cycle, no ack is ever issued for it, and the requester must re-request.

Verification
REQ-029 Fetch only, LAT=2, if_addr=0x010, mem_rdata=0x00000033 → mem_en high 2 cycles, if_ack one pulse 3 cycles after grant, if_rdata=0x00000033, d_ack stays 0.
REQ-030 if_req and d_req both high in IDLE, d_run=0, d_we=0, d_addr=0x100 → data granted first, d_ack then fetch granted, if_ack after LAT+2 cycles more.
REQ-031 d_req held high continuously with if_req high, MAX_D_RUN=4 → grant order D,D,D,D,I,D,D,D,D,I; no fetch waits more than 5 grants.
REQ-032 Store d_we=1, d_addr=0x040, d_func3=3'b010, d_wdata=0xDEADBEEF → mem_we=1 only during ACCESS with those exact values; d_rdata unchanged; if-side untouched.
REQ-033 rst=0 asserted mid-ACCESS of a store → next cycle mem_en=mem_we=0, busy=0, no d_ack; after release, the still-high d_req is granted fresh with full LAT latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates instruction-fetch and data requests onto one
//            fixed-latency single-port memory. Data has priority, but a
//            pending fetch wins after MAX_D_RUN back-to-back data grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int LAT       = 2,
   parameter int MAX_D_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [2:0]        d_func3,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_func3,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,

   output logic              busy
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int RUN_W = (MAX_D_RUN > 0) ? $clog2(MAX_D_RUN + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);
   // Fetches are always full-word reads.
   localparam logic [2:0]       FUNC3_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [RUN_W-1:0]   d_run;
   logic               owner_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [2:0]         func3_q;
   logic               we_q;
   logic [31:0]        wdata_q;
   logic [31:0]        if_rdata_q;
   logic [31:0]        d_rdata_q;
   logic               grant;
   logic               grant_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         d_run      <= '0;
         owner_d    <= 1'b0;
         addr_q     <= '0;
         func3_q    <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            owner_d <= grant_d;
            addr_q  <= grant_d ? d_addr  : if_addr;
            func3_q <= grant_d ? d_func3 : FUNC3_WORD;
            we_q    <= grant_d ? d_we    : 1'b0;
            wdata_q <= grant_d ? d_wdata : 32'h0;
            cnt     <= CNT_LOAD;
            if (grant_d) begin
               if (d_run != RUN_MAX)
                  d_run <= d_run + 1'b1;
            end else begin
               d_run <= '0;
            end
         end
         if (state == ACCESS) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else if (!owner_d) begin
               if_rdata_q <= mem_rdata;
            end else if (!we_q) begin
               // Stores leave the load-data register untouched.
               d_rdata_q <= mem_rdata;
            end
         end
      end
   end

   always_comb begin
      state_nx  = state;
      grant     = 1'b0;
      grant_d   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      if_ack    = 1'b0;
      d_ack     = 1'b0;
      busy      = (state != IDLE);
      mem_addr  = addr_q;
      mem_func3 = func3_q;
      mem_wdata = wdata_q;
      case (state)
         IDLE: begin
            if (d_req && !(if_req && (d_run == RUN_MAX))) begin
               grant    = 1'b1;
               grant_d  = 1'b1;
               state_nx = ACCESS;
            end else if (if_req) begin
               grant    = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            mem_en = 1'b1;
            mem_we = we_q;
            if (cnt == '0)
               state_nx = DONE;
         end
         DONE: begin
            if_ack   = !owner_d;
            d_ack    = owner_d;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (LAT=2,
//            MAX_D_RUN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int ADDR_W = 12;
   localparam int LAT    = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_ack;
   logic [31:0]       if_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [2:0]        d_func3 = '0;
   logic [31:0]       d_wdata = '0;
   logic              d_ack;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [2:0]        mem_func3;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = '0;
   logic              busy;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .MAX_D_RUN(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func3(d_func3),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advances until an ack appears (bounded); n is the number of edges taken.
   task automatic wait_ack(output logic got_if, output logic got_d, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(if_ack || d_ack) && n < 20);
      got_if = if_ack;
      got_d  = d_ack;
   endtask

   initial begin
      logic       gi, gd;
      int         n;
      logic [9:0] order_exp;

      // Reset state, idle with no requests
      tick(); tick();
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      rst = 1'b1;
      tick();
      chk("idle_no_req_en", {31'b0, mem_en}, 32'd0);
      chk("idle_no_req_busy", {31'b0, busy}, 32'd0);

      // Fetch only
      if_req = 1'b1; if_addr = 12'h010; mem_rdata = 32'h0000_0033;
      tick();
      chk("f_acc1_en", {31'b0, mem_en}, 32'd1);
      chk("f_acc1_addr", {20'b0, mem_addr}, 32'h010);
      chk("f_acc1_we", {31'b0, mem_we}, 32'd0);
      chk("f_acc1_busy", {31'b0, busy}, 32'd1);
      tick();
      chk("f_acc2_en", {31'b0, mem_en}, 32'd1);
      chk("f_acc2_ack", {31'b0, if_ack}, 32'd0);
      tick();
      chk("f_done_ack", {30'b0, if_ack, d_ack}, 32'b10);
      chk("f_done_en", {31'b0, mem_en}, 32'd0);
      chk("f_rdata", if_rdata, 32'h0000_0033);
      if_req = 1'b0;
      tick();
      chk("f_idle_ack", {30'b0, if_ack, d_ack}, 32'd0);
      chk("f_idle_busy", {31'b0, busy}, 32'd0);

      // Both requesting with d_run=0: data first, then fetch
      if_req = 1'b1; if_addr = 12'h020;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h100; d_func3 = 3'b010;
      mem_rdata = 32'hA5A5_0001;
      tick();
      chk("both_grant_addr", {20'b0, mem_addr}, 32'h100);
      tick(); tick();
      chk("both_d_ack", {30'b0, if_ack, d_ack}, 32'b01);
      chk("both_d_rdata", d_rdata, 32'hA5A5_0001);
      d_req = 1'b0; mem_rdata = 32'h1111_2222;
      wait_ack(gi, gd, n);
      chk("both_if_ack", {30'b0, gi, gd}, 32'b10);
      chk("both_if_gap", n, LAT + 2);
      chk("both_if_rdata", if_rdata, 32'h1111_2222);
      chk("both_d_hold", d_rdata, 32'hA5A5_0001);
      if_req = 1'b0;
      tick();

      // Continuous contention: D,D,D,D,I,D,D,D,D,I (bit 9 = first grant)
      order_exp = 10'b1111011110;
      if_req = 1'b1; if_addr = 12'h030;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h104;
      mem_rdata = 32'h0BAD_F00D;
      for (int k = 0; k < 10; k++) begin
         wait_ack(gi, gd, n);
         chk($sformatf("order_%0d", k), {30'b0, gi, gd}, order_exp[9-k] ? 32'b01 : 32'b10);
         chk($sformatf("gap_%0d", k), n, (k == 0) ? LAT + 1 : LAT + 2);
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();

      // Store
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h040; d_func3 = 3'b010;
      d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h9999_9999;
      chk("st_idle_we", {31'b0, mem_we}, 32'd0);
      tick();
      chk("st_we", {31'b0, mem_we}, 32'd1);
      chk("st_addr", {20'b0, mem_addr}, 32'h040);
      chk("st_func3", {29'b0, mem_func3}, 32'd2);
      chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("st_we2", {31'b0, mem_we}, 32'd1);
      tick();
      chk("st_ack", {30'b0, if_ack, d_ack}, 32'b01);
      chk("st_done_we", {31'b0, mem_we}, 32'd0);
      chk("st_d_rdata", d_rdata, 32'h0BAD_F00D);
      chk("st_if_rdata", if_rdata, 32'h0BAD_F00D);
      d_req = 1'b0;
      tick();

      // Reset mid-ACCESS of a store, then fresh grant
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h080; d_wdata = 32'h1234_5678;
      tick();
      chk("ra_we", {31'b0, mem_we}, 32'd1);
      rst = 1'b0;
      tick();
      chk("ra_en", {31'b0, mem_en}, 32'd0);
      chk("ra_we_off", {31'b0, mem_we}, 32'd0);
      chk("ra_busy", {31'b0, busy}, 32'd0);
      chk("ra_no_ack", {31'b0, d_ack}, 32'd0);
      rst = 1'b1;
      wait_ack(gi, gd, n);
      chk("ra_regrant_ack", {30'b0, gi, gd}, 32'b01);
      chk("ra_regrant_lat", n, LAT + 1);
      chk("ra_d_rdata", d_rdata, 32'd0);
      d_req = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
